// File: rtl/instr_encoder.sv
// instr_encoder
//   Packs control-level instruction tuples (class, ALUControl code, registers,
//   immediate) into RV32I machine words. The words are queued in a small FIFO
//   and streamed to an instruction-memory write port, one word per pop, with a
//   byte address that advances by 4 on every accepted write.
//
//   Optional feature macro: ENC_ILLEGAL_CHECK_EN
//     defined   : illegal tuples are consumed but dropped; err goes high the
//                 cycle after and stays high until reset.
//     undefined : illegal tuples are queued as NOP (addi x0,x0,0); err is 0.
//
// Parameters
//   DEPTH      FIFO entries (power of 2, >= 2)
//   ADDR_W     width of imem_addr
//   BASE_ADDR  first write address after reset / addr_clr
//
// Ports
//   clk, rst              clock; asynchronous active-low reset
//   addr_clr              reload the address counter to BASE_ADDR
//   in_valid / in_ready   tuple handshake (in_ready = FIFO not full)
//   in_class, in_alu_ctrl instruction class and ALUControl code
//   in_rd, in_rs1, in_rs2 register fields
//   in_imm                two's-complement immediate
//   out_valid / out_ready imem write handshake
//   imem_addr, imem_wdata write address and encoded word
//   level                 FIFO occupancy
//   err                   sticky illegal-tuple flag
module instr_encoder #(
  parameter int                 DEPTH     = 4,
  parameter int                 ADDR_W    = 32,
  parameter logic [ADDR_W-1:0]  BASE_ADDR = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     addr_clr,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [2:0]               in_class,
  input  logic [2:0]               in_alu_ctrl,
  input  logic [4:0]               in_rd,
  input  logic [4:0]               in_rs1,
  input  logic [4:0]               in_rs2,
  input  logic [31:0]              in_imm,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ADDR_W-1:0]        imem_addr,
  output logic [31:0]              imem_wdata,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     err
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_LVL = (PW+1)'(DEPTH);

  // class codes
  localparam logic [2:0] CL_R      = 3'b000;
  localparam logic [2:0] CL_I      = 3'b001;
  localparam logic [2:0] CL_LOAD   = 3'b010;
  localparam logic [2:0] CL_STORE  = 3'b011;
  localparam logic [2:0] CL_BRANCH = 3'b100;

  // ALUControl codes
  localparam logic [2:0] AC_ADD = 3'b000;
  localparam logic [2:0] AC_SUB = 3'b001;
  localparam logic [2:0] AC_OR  = 3'b010;
  localparam logic [2:0] AC_AND = 3'b011;
  localparam logic [2:0] AC_SLT = 3'b101;

  // RV32I opcodes
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [2:0]  cls;
    logic [2:0]  alu;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
  } enc_req_t;

  enc_req_t req;
  assign req = '{cls: in_class, alu: in_alu_ctrl, rd: in_rd,
                 rs1: in_rs1, rs2: in_rs2, imm: in_imm};

  // No format uses immediate bits above 12.
  logic unused_imm_hi;
  assign unused_imm_hi = ^req.imm[31:13];

  // ---------------------------------------------------------------------------
  // Encoder (combinational, feeds FIFO write port directly)
  // ---------------------------------------------------------------------------
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic        alu_ok;
  logic [31:0] raw_word;
  logic        enc_illegal;
  logic [31:0] enc_word;

  always_comb begin
    f3     = 3'b000;
    f7     = 7'b0000000;
    alu_ok = 1'b1;
    case (req.alu)
      AC_ADD:  f3 = 3'b000;
      AC_SUB:  begin f3 = 3'b000; f7 = 7'b0100000; end
      AC_OR:   f3 = 3'b110;
      AC_AND:  f3 = 3'b111;
      AC_SLT:  f3 = 3'b010;
      default: alu_ok = 1'b0;
    endcase
  end

  always_comb begin
    raw_word    = NOP;
    enc_illegal = 1'b0;
    case (req.cls)
      CL_R: begin
        raw_word    = {f7, req.rs2, req.rs1, f3, req.rd, OP_R};
        enc_illegal = !alu_ok;
      end
      CL_I: begin
        // funct7 is never carried for I-ALU; there is no "subi".
        raw_word    = {req.imm[11:0], req.rs1, f3, req.rd, OP_I};
        enc_illegal = !alu_ok || (req.alu == AC_SUB);
      end
      CL_LOAD:
        raw_word = {req.imm[11:0], req.rs1, 3'b010, req.rd, OP_LOAD};
      CL_STORE:
        raw_word = {req.imm[11:5], req.rs2, req.rs1, 3'b010,
                    req.imm[4:0], OP_STORE};
      CL_BRANCH:
        // imm[0] is implicitly zero in the B format and is dropped.
        raw_word = {req.imm[12], req.imm[10:5], req.rs2, req.rs1, 3'b000,
                    req.imm[4:1], req.imm[11], OP_BRANCH};
      default:
        enc_illegal = 1'b1;
    endcase
  end

  assign enc_word = enc_illegal ? NOP : raw_word;

  // ---------------------------------------------------------------------------
  // Handshakes
  // ---------------------------------------------------------------------------
  logic [PW:0] wr_ptr, rd_ptr;
  logic        full;
  logic        accept;
  logic        push;
  logic        pop;

  assign level     = wr_ptr - rd_ptr;
  assign full      = (level == FULL_LVL);
  assign out_valid = (level != '0);
  assign in_ready  = !full;
  assign accept    = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

`ifdef ENC_ILLEGAL_CHECK_EN
  // Illegal tuples complete the handshake but never reach the FIFO.
  assign push = accept && !enc_illegal;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                        err <= 1'b0;
    else if (accept && enc_illegal)  err <= 1'b1;
  end
`else
  // Illegal tuples already encode to NOP above.
  assign push = accept;
  assign err  = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // FIFO storage and pointers. Pointers carry one extra wrap bit so that
  // occupancy is a plain subtraction.
  // ---------------------------------------------------------------------------
  logic [DEPTH-1:0][31:0] mem;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[PW-1:0]] <= enc_word;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Gate with out_valid so the port reads zero while empty (incl. reset).
  assign imem_wdata = out_valid ? mem[rd_ptr[PW-1:0]] : 32'h0;

  // ---------------------------------------------------------------------------
  // Write address: +4 per pop, wraps naturally; addr_clr overrides a pop.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          imem_addr <= BASE_ADDR;
    else if (addr_clr) imem_addr <= BASE_ADDR;
    else if (pop)      imem_addr <= imem_addr + ADDR_W'(4);
  end

endmodule
